// File: rtl/cla_pipe_pkg.sv
// Shared defaults and per-stage record for the pipelined carry-look-ahead adder.
// Optional subtract support is enabled by defining CLA_PIPE_ADDER_SUB_EN.
package cla_pipe_pkg;
   localparam int DEF_WIDTH = 16;
   localparam int DEF_GROUP = 4;

   typedef struct packed {
      logic                 valid;
      logic [DEF_WIDTH-1:0] psum;
      logic [DEF_WIDTH-1:0] a_rem;
      logic [DEF_WIDTH-1:0] b_rem;
      logic                 carry;
      logic                 msb_cin;
   } stage_t;
endpackage

// File: rtl/cla_pipe_adder_group.sv
// Combinational GROUP-bit carry-look-ahead slice; every carry is a flat
// sum-of-products of g/p/ci, so there is no ripple path inside the slice.
module cla_group #(
   parameter int GROUP = 4
) (
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   input  logic             ci,
   output logic [GROUP-1:0] s,
   output logic             co,
   output logic             c_msb
);
   logic [GROUP-1:0] g, p;
   logic [GROUP:0]   c;
   logic             term;

   assign g = a & b;
   assign p = a ^ b;

   always_comb begin
      c    = '0;
      term = 1'b0;
      c[0] = ci;
      for (int i = 1; i <= GROUP; i++) begin
         term = ci;
         for (int k = 0; k < i; k++) term = term & p[k];
         c[i] = term;
         for (int j = 0; j < i; j++) begin
            term = g[j];
            for (int k = j + 1; k < i; k++) term = term & p[k];
            c[i] = c[i] | term;
         end
      end
   end

   assign s     = p ^ c[GROUP-1:0];
   assign co    = c[GROUP];
   assign c_msb = c[GROUP-1];
endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder: one GROUP-bit slice per stage, carry registered between
// stages, global stall. Define CLA_PIPE_ADDER_SUB_EN to add the sub input.
module cla_pipe_adder
   import cla_pipe_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int GROUP = DEF_GROUP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef CLA_PIPE_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int NSTG = WIDTH / GROUP;

   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] psum;
      logic [WIDTH-1:0] a_rem;
      logic [WIDTH-1:0] b_rem;
      logic             carry;
      logic             msb_cin;
   } stg_t;

   logic [WIDTH-1:0] b_eff;
   logic             c_eff;
   logic             advance;
   stg_t             last;

`ifdef CLA_PIPE_ADDER_SUB_EN
   // a - b == a + ~b + 1; cin is ignored while subtracting
   assign b_eff = sub ? ~b : b;
   assign c_eff = sub | cin;
`else
   assign b_eff = b;
   assign c_eff = cin;
`endif

   assign advance = !last.valid | out_ready;

   for (genvar k = 0; k < NSTG; k++) begin : g_stg
      stg_t             prv, nxt, r;
      logic [GROUP-1:0] s;
      logic             co, cm;

      if (k == 0) begin : g_head
         assign prv = '{valid: in_valid, psum: '0, a_rem: a, b_rem: b_eff,
                        carry: c_eff, msb_cin: 1'b0};
      end else begin : g_tail
         assign prv = g_stg[k-1].r;
      end

      cla_group #(.GROUP(GROUP)) u_grp (
         .a     (prv.a_rem[GROUP*k +: GROUP]),
         .b     (prv.b_rem[GROUP*k +: GROUP]),
         .ci    (prv.carry),
         .s     (s),
         .co    (co),
         .c_msb (cm)
      );

      always_comb begin
         nxt                        = prv;
         nxt.psum[GROUP*k +: GROUP] = s;
         nxt.carry                  = co;
         nxt.msb_cin                = cm;
      end

      always_ff @(posedge clk) begin
         if (rst)          r <= '0;
         else if (advance) r <= nxt;
      end
   end

   assign last = g_stg[NSTG-1].r;

   // handshakes are masked while rst is high so nothing transfers in that cycle
   assign in_ready  = advance & !rst;
   assign out_valid = last.valid & !rst;
   assign sum       = last.psum;
   assign cout      = last.carry;
   assign ovf       = last.carry ^ last.msb_cin;
endmodule
